gcd_arbiter: RTL

//  Shares one GCD core among NREQ requesters. Round-robin selects a pending request and issues it to the core.
//  It captures the core's one-cycle result pulse and returns the result to the originating requester.

---
 rtl/gcd_arb_pkg.sv | 27 ++
 rtl/gcd_arbiter_rr_picker.sv | 46 ++++
 rtl/gcd_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/gcd_arb_pkg.sv
// Shared types and constants for the GCD-core arbiter.
// Used by gcd_arbiter and rr_picker.
package gcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int GCD_OPW = 16;
  localparam int GCD_INW = 32;

  localparam logic [GCD_OPW-1:0] GCD_TIMEOUT_RESULT = 16'hFFFF;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    if (idx + 32'd1 >= n) begin
      nxt = 32'd0;
    end else begin
      nxt = idx + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gcd_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
// Produces a one-hot grant, its index, and a flag that any request is set.
module rr_picker
  import gcd_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  localparam int SW = IDW + 1;

  logic [SW-1:0]  sum_s;
  logic [IDW-1:0] cand_s;

  // Scan candidates ptr, ptr+1, ... (mod NREQ); the first pending one wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr_i} + SW'(k);
      if (sum_s >= SW'(NREQ)) begin
        sum_s = sum_s - SW'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IDW-1:0];
      if (!any_o && req_i[cand_s]) begin
        any_o           = 1'b1;
        idx_o           = cand_s;
        grant_o[cand_s] = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD core among NREQ requesters, one job in flight.
// Optional WAIT watchdog with a timeout output port: define GCD_ARB_WDOG_EN.
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter  int NREQ        = 4,
  parameter  int WDOG_CYCLES = 70000,
  localparam int IDW         = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*GCD_INW-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [GCD_OPW-1:0]      rsp_data,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic                    gcd_in_valid,
  output logic [GCD_INW-1:0]      gcd_in_data,
  input  logic                    gcd_in_ready,
  input  logic                    gcd_out_valid,
  input  logic [GCD_OPW-1:0]      gcd_out_data,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id
`ifdef GCD_ARB_WDOG_EN
  ,
  output logic                    timeout
`endif
);

  if (NREQ < 2 || NREQ > 8 || WDOG_CYCLES < 1) begin : g_param_check
    $error("gcd_arbiter: parameter out of range");
  end

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [GCD_OPW-1:0]   rsp_data_q, rsp_data_d;
  logic                 post_rst_q;

  logic [NREQ-1:0]      pick_grant;
  logic [IDW-1:0]       pick_idx;
  logic                 pick_any;
  logic                 fire;
  logic                 rsp_hs;
  logic                 wdog_hit;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // No issue while reset is asserted nor in the first cycle after it.
  assign fire   = (state_q == IDLE) && gcd_in_ready && pick_any && !reset && !post_rst_q;
  assign rsp_hs = (state_q == RESP) && rsp_ready[grant_id_q];

`ifdef GCD_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] wdog_q, wdog_d;
  logic          timeout_q, timeout_d;

  assign wdog_hit = (state_q == WAIT) && (wdog_q == CW'(WDOG_CYCLES));
  assign timeout  = timeout_q & ~reset;

  // Watchdog counter and timeout flag next-state.
  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (fire) begin
      wdog_d = '0;
    end else if (state_q == WAIT && !wdog_hit) begin
      wdog_d = wdog_q + CW'(1);
    end else begin
      wdog_d = wdog_q;
    end
    // A real result arriving on the expiry cycle wins over the timeout.
    if (wdog_hit && !gcd_out_valid) begin
      timeout_d = 1'b1;
    end else if (rsp_hs) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  // FSM next-state, combinational accept toward requester and core.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    rsp_data_d   = rsp_data_q;
    req_ready    = '0;
    gcd_in_valid = 1'b0;
    gcd_in_data  = '0;
    case (state_q)
      IDLE: begin
        if (fire) begin
          req_ready    = pick_grant;
          gcd_in_valid = 1'b1;
          gcd_in_data  = req_data[GCD_INW*pick_idx +: GCD_INW];
          grant_id_d   = pick_idx;
          state_d      = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (gcd_out_valid) begin
          rsp_data_d = gcd_out_data;
          state_d    = RESP;
        end else if (wdog_hit) begin
          rsp_data_d = GCD_TIMEOUT_RESULT;
          state_d    = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          rr_ptr_d = IDW'(rr_next(32'(grant_id_q), 32'(NREQ)));
          state_d  = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response strobe toward the owner of the held result.
  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP && !reset) begin
      rsp_valid[grant_id_q] = 1'b1;
    end else begin
      rsp_valid = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      rsp_data_q <= '0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      rsp_data_q <= rsp_data_d;
      post_rst_q <= 1'b0;
    end
  end

  assign busy     = (state_q != IDLE) && !reset;
  assign grant_id = grant_id_q;
  assign rsp_data = rsp_data_q;

endmodule
